// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed hex 7-segment driver.
// A new value is staged in a pending register and moved into the display
// register only on a frame boundary, so one scan never shows two values.
module seg7_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  blank_lz,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;      // {a,b,c,d,e,f,g}
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                fd_q, fd_d;

  logic                slot_end, boundary;
  logic [4*DIGITS-1:0] load_val;
  logic [DIGITS-1:0]   blank;
  logic                zero_run;
  logic [3:0]          nib;

  // Hex digit to active-high segments {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'b1111110;
      4'h1: hex2seg = 7'b0110000;
      4'h2: hex2seg = 7'b1101101;
      4'h3: hex2seg = 7'b1111001;
      4'h4: hex2seg = 7'b0110011;
      4'h5: hex2seg = 7'b1011011;
      4'h6: hex2seg = 7'b1011111;
      4'h7: hex2seg = 7'b1110000;
      4'h8: hex2seg = 7'b1111111;
      4'h9: hex2seg = 7'b1111011;
      4'hA: hex2seg = 7'b1110111;
      4'hB: hex2seg = 7'b0011111;
      4'hC: hex2seg = 7'b1001110;
      4'hD: hex2seg = 7'b0111101;
      4'hE: hex2seg = 7'b1001111;
      default: hex2seg = 7'b1000111;
    endcase
  endfunction

  // Scan sequencing and tear-free commit of the pending value.
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    boundary  = enable && slot_end && (idx_q == IDX_LAST);
    // A load on the commit edge bypasses pending so it is not a frame late.
    load_val  = load ? value : pending_q;
    pending_d = load_val;
    disp_d    = disp_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (!enable) begin
      cnt_d  = '0;
      idx_d  = '0;
      disp_d = load_val;
    end else begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (boundary) disp_d = load_val;
    end
    fd_d = boundary;
  end

  // Leading-zero mask: digit i>0 is dark when it and every higher nibble is 0.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (disp_q[4*i +: 4] == 4'h0);
      blank[i] = blank_lz && zero_run;
    end
  end

  // Decode the current slot; blanked slots keep their dwell but stay dark.
  always_comb begin
    nib      = disp_q[4*idx_q +: 4];
    seg_d    = '0;
    dig_en_d = '0;
    if (enable && !blank[idx_q]) begin
      seg_d    = hex2seg(nib);
      dig_en_d = DIGITS'(1) << idx_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      disp_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      seg_q     <= '0;
      dig_en_q  <= '0;
      fd_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_en_q  <= dig_en_d;
      fd_q      <= fd_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign dig_en                = dig_en_q;
  assign frame_done            = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (DIGITS=4, REFRESH_DIV=4).
// The reference model tracks a scan position within the frame and the
// value shown for the current frame; expectations are queued per edge and
// a negedge monitor pops and compares them against the DUT outputs.
module tb_seg7_scan_mux;
  localparam int D  = 4;
  localparam int RD = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0, enable = 1'b0, blank_lz = 1'b0;
  logic        a, b, c, d, e, f, g, frame_done;
  logic [3:0]  dig_en;

  seg7_scan_mux #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .enable(enable),
    .blank_lz(blank_lz), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  // Segment letters lit for each hex digit.
  string PAT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  localparam byte CH_A = "a";

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] r;
    string s;
    r = '0;
    s = PAT[n];
    for (int k = 0; k < s.len(); k++) r[6 - (int'(s[k]) - int'(CH_A))] = 1'b1;
    return r;
  endfunction

  // Reference model state.
  logic [15:0] m_pend, m_frame;
  int          m_pos;   // cycles into current frame, 0..D*RD-1
  logic [15:0] g_val;
  logic        g_en, g_blz;

  task automatic model_reset();
    m_pend = '0; m_frame = '0; m_pos = 0;
  endtask

  task automatic model_edge(input logic [15:0] v, input logic ld, input logic en, input logic blz);
    exp_t x;
    logic [15:0] lv, hi;
    int dig;
    x  = '0;
    lv = ld ? v : m_pend;
    if (en) begin
      dig = (m_pos / RD) % D;
      hi  = m_frame >> (4 * dig);
      if (!(blz && dig > 0 && hi == 16'h0)) begin
        x.dig = 4'b0001 << dig;
        x.seg = seg_of(hi[3:0]);
      end
      if ((m_pos + 1) % (D * RD) == 0) begin
        x.fd    = 1'b1;
        m_frame = lv;
      end
      m_pos = (m_pos + 1) % (D * RD);
    end else begin
      m_frame = lv;
      m_pos   = 0;
    end
    m_pend = lv;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic ld);
    value = g_val; load = ld; enable = g_en; blank_lz = g_blz;
    @(posedge clk);
    model_edge(g_val, ld, g_en, g_blz);
    #1 load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0);
  endtask

  task automatic do_load(input logic [15:0] v);
    g_val = v;
    cyc(1'b1);
  endtask

  task automatic run_to_pos(input int target);
    for (int k = 0; k < 64 && m_pos != target; k++) cyc(1'b0);
  endtask

  task automatic reset_hold(input int n);
    model_reset();
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      exp_q.push_back('0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a, b, c, d, e, f, g} !== 7'b0 || dig_en !== 4'b0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got seg=%b dig_en=%b fd=%b, expected all 0",
               {a, b, c, d, e, f, g}, dig_en, frame_done);
    end
    reset_hold(2);
  endtask

  // Monitor: compare each edge's registered outputs away from the edge.
  always @(negedge clk) begin : mon
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if ({a, b, c, d, e, f, g} !== x.seg || dig_en !== x.dig || frame_done !== x.fd) begin
        n_err++;
        $display("FAIL scan_out t=%0t: got seg=%b dig_en=%b fd=%b, expected seg=%b dig_en=%b fd=%b",
                 $time, {a, b, c, d, e, f, g}, dig_en, frame_done, x.seg, x.dig, x.fd);
      end
    end
  end

  initial begin
    g_val = '0; g_en = 1'b0; g_blz = 1'b0;
    model_reset();
    // Reset, then load 0x0A3F while dark and start scanning.
    reset_hold(3);
    do_load(16'h0A3F);
    run(1);
    g_en = 1'b1;
    run(36);
    // Tear-free update: 0x1234 then 0x5678 loaded during digit 1.
    do_load(16'h1234);
    run_to_pos(0);
    run(5);
    do_load(16'h5678);
    run(32);
    // Load on the frame boundary edge.
    run_to_pos(D * RD - 1);
    do_load(16'hBEEF);
    run(20);
    // Leading-zero blanking.
    g_blz = 1'b1;
    do_load(16'h0030);
    run(34);
    do_load(16'h0000);
    run(34);
    g_blz = 1'b0;
    run(20);
    // Enable dropped mid-digit-2, then resumed.
    do_load(16'h9C7D);
    run_to_pos(0);
    run_to_pos(9);
    g_en = 1'b0;
    run(3);
    g_en = 1'b1;
    run(20);
    // Asynchronous reset mid-slot with enable held high.
    run_to_pos(6);
    async_reset();
    run(20);
    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(31) == 0) g_en = ~g_en;
      if ($urandom_range(47) == 0) g_blz = ~g_blz;
      if ($urandom_range(7) == 0) do_load(16'($urandom) >> (4 * $urandom_range(3)));
      else run(1);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
